// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice: FSM states, reset PC
// default and instruction field bounds.
package fetch_pkg;

    localparam int INSTR_W = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } fetchState_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds the fetched instruction and its PC+4.
// A flush wins over a capture, and a capture wins over hold/drain.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               capture,
    input  logic               flush,
    input  logic               hold,
    input  logic [INSTR_W-1:0] instrIn,
    input  logic [31:0]        pcPlus4In,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pcPlus4,
    output logic               valid
);

    // Load on capture, drop the valid flag on flush or when decode consumed it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr   <= '0;
            pcPlus4 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            valid   <= 1'b0;
        end else if (capture) begin
            instr   <= instrIn;
            pcPlus4 <= pcPlus4In;
            valid   <= 1'b1;
        end else if (valid && !hold) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC and the request FSM, feeds the IF/ID
// register. A redirect during an outstanding read parks the FSM in S_DROP
// until the stale read completes, so the memory only ever sees one
// transaction at a time.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | one-cycle post-reset bubble, no request
//   S_FETCH | requesting at PC unless a live instruction is being stalled
//   S_DROP  | waiting out a read issued before a redirect; data discarded
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imemReq_o,
    output logic [31:0]        imemAddr_o,
    input  logic [INSTR_W-1:0] imemRdata_i,
    input  logic               imemValid_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirectPc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [5:0]         opcode_o,
    output logic [31:0]        pcPlus4_o,
    output logic               valid_o
);

    fetchState_t state;
    logic [31:0] pc;
    logic [31:0] dropAddr;
    logic [31:0] redirectTarget;
    logic        capture;
    logic        unusedRedirectLsbs;

    assign redirectTarget     = wordAlign(redirectPc_i);
    assign unusedRedirectLsbs = ^redirectPc_i[1:0];

    assign imemReq_o  = (state == S_DROP) || ((state == S_FETCH) && !(valid_o && stall_i));
    assign imemAddr_o = (state == S_DROP) ? dropAddr : pc;
    assign capture    = (state == S_FETCH) && imemReq_o && imemValid_i && !redirect_i;
    assign opcode_o   = instr_o[OPC_MSB:OPC_LSB];

    // PC and request FSM; a redirect always overrides capture and stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            pc       <= wordAlign(RESET_PC);
            dropAddr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_FETCH;
                    if (redirect_i) pc <= redirectTarget;
                end
                S_FETCH: begin
                    if (redirect_i) begin
                        pc <= redirectTarget;
                        if (imemReq_o && !imemValid_i) begin
                            state    <= S_DROP;
                            dropAddr <= pc;
                        end
                    end else if (capture) begin
                        pc <= pc + 32'd4;
                    end
                end
                S_DROP: begin
                    if (redirect_i) pc <= redirectTarget;
                    if (imemValid_i) state <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    if_id_reg uIfId (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture   (capture),
        .flush     (redirect_i),
        .hold      (stall_i),
        .instrIn   (imemRdata_i),
        .pcPlus4In (pc + 32'd4),
        .instr     (instr_o),
        .pcPlus4   (pcPlus4_o),
        .valid     (valid_o)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized stall,
// redirect, reset and memory latency, checked against a transaction-level
// reference model. A second instance with a wrapping reset PC runs against
// a 0-wait memory.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imemReq_o;
    logic [31:0] imemAddr_o;
    logic [31:0] imemRdata_i;
    logic        imemValid_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirectPc_i;
    logic [31:0] instr_o;
    logic [5:0]  opcode_o;
    logic [31:0] pcPlus4_o;
    logic        valid_o;

    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic [5:0]  opcode2;
    logic [31:0] pcPlus4_2;
    logic        valid2;

    int nCompared   = 0;
    int nMismatched = 0;

    always #5 clk_i = ~clk_i;

    fetch_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imemReq_o    (imemReq_o),
        .imemAddr_o   (imemAddr_o),
        .imemRdata_i  (imemRdata_i),
        .imemValid_i  (imemValid_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirectPc_i (redirectPc_i),
        .instr_o      (instr_o),
        .opcode_o     (opcode_o),
        .pcPlus4_o    (pcPlus4_o),
        .valid_o      (valid_o)
    );

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return addr ^ 32'h8C01_0004;
    endfunction

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imemReq_o    (req2),
        .imemAddr_o   (addr2),
        .imemRdata_i  (memData(addr2)),
        .imemValid_i  (req2),
        .stall_i      (1'b0),
        .redirect_i   (1'b0),
        .redirectPc_i (32'h0),
        .instr_o      (instr2),
        .opcode_o     (opcode2),
        .pcPlus4_o    (pcPlus4_2),
        .valid_o      (valid2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: what the fetch unit should present, tracked per transaction.
    bit          mStarted;
    logic [31:0] mPc;
    bit          mValid;
    logic [31:0] mInstr;
    logic [31:0] mP4;
    bit          mDiscard;
    logic [31:0] mDiscardAddr;

    // Memory model state.
    bit          busy;
    int          cnt;
    logic [31:0] bAddr;

    task automatic modelReset();
        mStarted = 0;
        mPc      = 32'h0;
        mValid   = 0;
        mInstr   = 32'h0;
        mP4      = 32'h0;
        mDiscard = 0;
        busy     = 0;
    endtask

    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input int lat, input bit rs);
        bit          expReq;
        logic [31:0] expAddr;
        bit          done;
        @(negedge clk_i);
        stall_i      = st;
        redirect_i   = rd;
        redirectPc_i = rpc;
        rst_i        = rs;
        #1;
        expReq  = mStarted && (mDiscard || !(mValid && st));
        expAddr = mDiscard ? mDiscardAddr : mPc;
        chk("req", {31'b0, imemReq_o}, {31'b0, expReq});
        if (expReq) chk("addr", imemAddr_o, expAddr);

        imemValid_i = 1'b0;
        imemRdata_i = $urandom;
        if (rs) begin
            busy = 0;
        end else if (imemReq_o) begin
            if (!busy) begin
                busy  = 1;
                cnt   = lat;
                bAddr = imemAddr_o;
            end else begin
                chk("addrStable", imemAddr_o, bAddr);
            end
            if (cnt == 0) begin
                imemValid_i = 1'b1;
                imemRdata_i = memData(bAddr);
                busy        = 0;
            end else begin
                cnt--;
            end
        end

        done = expReq && imemValid_i;
        if (rs) begin
            modelReset();
        end else if (!mStarted) begin
            mStarted = 1;
            if (rd) mPc = {rpc[31:2], 2'b00};
        end else if (rd) begin
            if (mDiscard) begin
                if (done) mDiscard = 0;
            end else if (expReq && !done) begin
                mDiscard     = 1;
                mDiscardAddr = mPc;
            end
            mPc    = {rpc[31:2], 2'b00};
            mValid = 0;
        end else if (mDiscard) begin
            if (done) mDiscard = 0;
        end else if (done) begin
            mInstr = imemRdata_i;
            mP4    = mPc + 32'd4;
            mPc    = mPc + 32'd4;
            mValid = 1;
        end else if (mValid && !st) begin
            mValid = 0;
        end

        @(posedge clk_i);
        #1;
        chk("valid", {31'b0, valid_o}, {31'b0, mValid});
        chk("instr", instr_o, mInstr);
        chk("pcPlus4", pcPlus4_o, mP4);
        chk("opcode", {26'b0, opcode_o}, {26'b0, mInstr[31:26]});
    endtask

    logic [31:0] savedInstr;

    initial begin
        rst_i        = 1'b1;
        stall_i      = 1'b0;
        redirect_i   = 1'b0;
        redirectPc_i = 32'h0;
        imemValid_i  = 1'b0;
        imemRdata_i  = 32'h0;
        modelReset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req", {31'b0, imemReq_o}, 32'h0);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_p4", pcPlus4_o, 32'h0);

        // First fetch from a 0-wait memory; wrapping instance runs alongside.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("r031_req_after_idle", {31'b0, imemReq_o}, 32'h1);
        chk("r031_addr", imemAddr_o, 32'h0);
        chk("r035_first_addr", addr2, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        chk("r031_valid", {31'b0, valid_o}, 32'h1);
        chk("r031_opcode", {26'b0, opcode_o}, {26'b0, 6'b100011});
        chk("r031_p4", pcPlus4_o, 32'h4);
        chk("r031_instr", instr_o, 32'h8C01_0004);
        chk("r035_second_addr", addr2, 32'h0);
        chk("r035_p4", pcPlus4_2, 32'h0);

        // Redirect while a 2-cycle read is outstanding.
        step(0, 0, 0, 2, 0);
        step(0, 1, 32'h0000_0043, 0, 0);
        chk("r033_drop_addr", imemAddr_o, 32'h4);
        chk("r033_drop_req", {31'b0, imemReq_o}, 32'h1);
        chk("r033_valid", {31'b0, valid_o}, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("r033_stale_hidden", {31'b0, valid_o}, 32'h0);
        chk("r033_new_addr", imemAddr_o, 32'h0000_0040);

        // Redirect coinciding with read completion and stall.
        step(1, 1, 32'h0000_0100, 0, 0);
        chk("r034_valid", {31'b0, valid_o}, 32'h0);
        chk("r034_addr", imemAddr_o, 32'h0000_0100);
        step(0, 0, 0, 0, 0);
        chk("r034_p4", pcPlus4_o, 32'h0000_0104);
        chk("r034_instr", instr_o, memData(32'h0000_0100));

        // Three-cycle stall holding a live instruction.
        savedInstr = instr_o;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            chk("r032_instr", instr_o, savedInstr);
            chk("r032_valid", {31'b0, valid_o}, 32'h1);
            chk("r032_req", {31'b0, imemReq_o}, 32'h0);
            chk("r032_pc", imemAddr_o, 32'h0000_0104);
        end
        step(0, 0, 0, 0, 0);
        chk("r032_resume_p4", pcPlus4_o, 32'h0000_0108);

        // Reset with a multi-cycle read outstanding.
        step(0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 1);
        chk("r036_req", {31'b0, imemReq_o}, 32'h0);
        chk("r036_valid", {31'b0, valid_o}, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("r036_addr", imemAddr_o, 32'h0);
        chk("r036_req_on", {31'b0, imemReq_o}, 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 8,
                 $urandom,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0,
                 $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
